// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like memory port between the CPU instruction and data ports and
// routes in-order responses via an outstanding-ID FIFO. Optional macro: ARB_RR_EN (round-robin grant).
module cpu_sram_arbiter #(
  parameter int OUT_DEPTH = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

  typedef enum logic {PORT_INST = 1'b0, PORT_DATA = 1'b1} port_e;

  logic                 lock;
  port_e                lock_id;
  port_e                gnt;
  logic [CW-1:0]        count;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [OUT_DEPTH-1:0] id_q;
  logic                 full;
  logic                 fire;
  logic                 pop;
  logic                 head_data;

`ifdef ARB_RR_EN
  port_e last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_grant <= PORT_INST;
    else if (fire) last_grant <= gnt;
  end
`endif

  // Grant: a locked (stalled) request keeps the port until its address handshake.
  always_comb begin
    gnt = PORT_INST;
    if (lock) gnt = lock_id;
`ifdef ARB_RR_EN
    else if (inst_req && data_req) gnt = (last_grant == PORT_INST) ? PORT_DATA : PORT_INST;
`endif
    else if (data_req) gnt = PORT_DATA;
  end

  assign full      = (count == FULL_CNT);
  assign mem_req   = ~reset & (inst_req | data_req) & ~full;
  assign fire      = mem_req & mem_addr_ok;
  assign pop       = ~reset & mem_data_ok & (count != '0);
  assign head_data = id_q[rd_ptr];

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_wstrb = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (!reset) begin
      if (gnt == PORT_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = 2'b10;
        mem_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = fire & (gnt == PORT_INST);
  assign data_addr_ok = fire & (gnt == PORT_DATA);
  assign inst_data_ok = pop & ~head_data;
  assign data_data_ok = pop & head_data;
  assign inst_rdata   = reset ? 32'h0 : mem_rdata;
  assign data_rdata   = reset ? 32'h0 : mem_rdata;

  // Control state: lock and FIFO bookkeeping; full comes from the registered count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock    <= 1'b0;
      lock_id <= PORT_INST;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (fire) begin
        lock <= 1'b0;
      end else if (mem_req) begin
        lock    <= 1'b1;
        lock_id <= gnt;
      end
      if (fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ID storage is pure data, guarded by count.
  always_ff @(posedge clk) begin
    if (fire) id_q[wr_ptr] <= gnt;
  end
endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed self-checking bench for cpu_sram_arbiter (expectations follow ARB_RR_EN when defined).
module tb_cpu_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  logic exp_d;

`ifdef ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  cpu_sram_arbiter #(.OUT_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    // Reset with busy inputs: every output must be zero
    reset = 1'b1;
    idle();
    inst_req = 1'b1; inst_addr = 32'h44; data_req = 1'b1; data_addr = 32'h55;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h99;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", data_data_ok, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_inst_rdata", inst_rdata, 32'h0);
    chk32("rst_count", 32'(dut.count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Test 1: reset while inst request is locked
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h100;
    #1;
    chk1("t1_mem_req", mem_req, 1'b1);
    chk1("t1_inst_addr_ok", inst_addr_ok, 1'b0);
    chk32("t1_mem_addr", mem_addr, 32'h100);
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h2000;
    #1;
    chk1("t1_lock", dut.lock, 1'b1);
    chk32("t1_locked_addr", mem_addr, 32'h100);
    chk1("t1_data_addr_ok", data_addr_ok, 1'b0);
    #1;
    reset = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk1("t1_rst_mem_req", mem_req, 1'b0);
    chk1("t1_rst_lock", dut.lock, 1'b0);
    chk1("t1_rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("t1_rst_data_addr_ok", data_addr_ok, 1'b0);
    chk1("t1_rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("t1_rst_data_data_ok", data_data_ok, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    chk32("t1_count", 32'(dut.count), 32'd0);
    chk1("t1_lock_after", dut.lock, 1'b0);

    // Test 2: both requesting, addr_ok every cycle
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h200;
    data_req = 1'b1; data_addr = 32'h3000; data_size = 2'b10;
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_d = (i == 1) ? ~RR : 1'b1;
      chk1("t2_data_addr_ok", data_addr_ok, exp_d);
      chk1("t2_inst_addr_ok", inst_addr_ok, ~exp_d);
      chk32("t2_mem_addr", mem_addr, exp_d ? 32'h3000 : 32'h200);
      @(negedge clk);
    end
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'h40 + 32'(i);
      #1;
      exp_d = (i == 1) ? ~RR : 1'b1;
      chk1("t2_data_data_ok", data_data_ok, exp_d);
      chk1("t2_inst_data_ok", inst_data_ok, ~exp_d);
      chk32("t2_rdata", exp_d ? data_rdata : inst_rdata, 32'h40 + 32'(i));
      @(negedge clk);
    end
    idle();
    #1;
    chk32("t2_count", 32'(dut.count), 32'd0);

    // Test 3: stalled data write holds the grant while inst arrives
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_wstrb = 4'hf;
    data_addr = 32'h1000; data_wdata = 32'hdeadbeef;
    #1;
    chk32("t3_c0_mem_addr", mem_addr, 32'h1000);
    chk1("t3_c0_mem_wr", mem_wr, 1'b1);
    chk1("t3_c0_data_addr_ok", data_addr_ok, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h400;
      #1;
      chk32("t3_stall_mem_addr", mem_addr, 32'h1000);
      chk1("t3_stall_inst_addr_ok", inst_addr_ok, 1'b0);
    end
    @(negedge clk);
    mem_addr_ok = 1'b1;
    #1;
    chk1("t3_data_addr_ok", data_addr_ok, 1'b1);
    chk1("t3_inst_addr_ok_blocked", inst_addr_ok, 1'b0);
    chk32("t3_mem_wdata", mem_wdata, 32'hdeadbeef);
    chk32("t3_mem_wstrb", 32'(mem_wstrb), 32'hf);
    @(negedge clk);
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    #1;
    chk1("t3_inst_addr_ok", inst_addr_ok, 1'b1);
    chk32("t3_inst_mem_addr", mem_addr, 32'h400);
    chk32("t3_inst_mem_size", 32'(mem_size), 32'd2);
    chk1("t3_inst_mem_wr", mem_wr, 1'b0);
    chk32("t3_inst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    @(negedge clk);
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0;
    #1;
    chk1("t3_write_ack", data_data_ok, 1'b1);
    chk1("t3_write_ack_inst", inst_data_ok, 1'b0);
    @(negedge clk);
    mem_rdata = 32'h1234;
    #1;
    chk1("t3_inst_data_ok", inst_data_ok, 1'b1);
    chk32("t3_inst_rdata", inst_rdata, 32'h1234);
    @(negedge clk);
    idle();

    // Test 4: fill FIFO, full blocks, one pop reopens a cycle later
    inst_req = 1'b1; inst_addr = 32'h500; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t4_fill_addr_ok", inst_addr_ok, 1'b1);
      @(negedge clk);
    end
    #1;
    chk1("t4_full_mem_req", mem_req, 1'b0);
    chk1("t4_full_addr_ok", inst_addr_ok, 1'b0);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'ha5;
    #1;
    chk1("t4_pop_data_ok", inst_data_ok, 1'b1);
    chk32("t4_pop_rdata", inst_rdata, 32'ha5);
    chk1("t4_bubble_mem_req", mem_req, 1'b0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk1("t4_reopen_mem_req", mem_req, 1'b1);
    chk1("t4_reopen_addr_ok", inst_addr_ok, 1'b1);
    @(negedge clk);
    idle();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("t4_drain_data_ok", inst_data_ok, 1'b1);
      @(negedge clk);
    end
    idle();
    #1;
    chk32("t4_count", 32'(dut.count), 32'd0);

    // Test 5: in-order return with push+pop in the same cycle
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hA00; mem_addr_ok = 1'b1;
    #1;
    chk1("t5_A_addr_ok", inst_addr_ok, 1'b1);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'hB00; data_size = 2'b10;
    #1;
    chk1("t5_B_addr_ok", data_addr_ok, 1'b1);
    @(negedge clk);
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hC00;
    mem_data_ok = 1'b1; mem_rdata = 32'h11;
    #1;
    chk1("t5_C_addr_ok", inst_addr_ok, 1'b1);
    chk1("t5_r1_inst_data_ok", inst_data_ok, 1'b1);
    chk1("t5_r1_data_data_ok", data_data_ok, 1'b0);
    chk32("t5_r1_rdata", inst_rdata, 32'h11);
    @(negedge clk);
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_rdata = 32'h22;
    #1;
    chk32("t5_count_kept", 32'(dut.count), 32'd2);
    chk1("t5_r2_data_data_ok", data_data_ok, 1'b1);
    chk1("t5_r2_inst_data_ok", inst_data_ok, 1'b0);
    chk32("t5_r2_rdata", data_rdata, 32'h22);
    @(negedge clk);
    mem_rdata = 32'h33;
    #1;
    chk1("t5_r3_inst_data_ok", inst_data_ok, 1'b1);
    chk1("t5_r3_data_data_ok", data_data_ok, 1'b0);
    chk32("t5_r3_rdata", inst_rdata, 32'h33);
    @(negedge clk);
    idle();
    #1;
    chk32("t5_count", 32'(dut.count), 32'd0);

    // Test 6: spurious response on an empty FIFO
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h77;
    #1;
    chk1("t6_inst_data_ok", inst_data_ok, 1'b0);
    chk1("t6_data_data_ok", data_data_ok, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk32("t6_count", 32'(dut.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
